// File: rtl/seg7_pkg.sv
// Shared types, segment constants and helpers for the 7-segment scan driver.
// Segment patterns are {a,b,c,d,e,f,g} in cathode polarity (1 = segment lit).
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7_dec.sv
// Combinational BCD to 7-segment decoder, cathode polarity.
// Codes 10..15 decode to the blank pattern; polarity is handled by the caller.
module bcd_to_seg7_dec
  import seg7_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // Table lookup of the lit segments for one digit.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver.
// A prescaler sets the dwell per digit; the digit index advances at each
// prescaler wrap. New BCD words are staged in a pending register and only
// committed to the display register at the frame wrap, so a frame never
// mixes old and new digits. The last cycle of every dwell is blanked to
// avoid ghosting onto the next digit.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zeros).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    LED_type_ctl,
  output logic [6:0]              LED,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] display;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_valid;

  logic                    dwell_end;
  logic                    wrap;
  bcd_t                    cur_digit;
  logic                    lead_blank;
  logic [6:0]              dec_seg;
  logic [6:0]              pattern;
  logic [6:0]              led_next;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   en_next;

  // Frame wrap happens on the last dwell cycle of the last digit; frame_tick
  // is decoded from registered state so it is high exactly in that cycle.
  assign dwell_end  = (prescaler == LAST_PRE);
  assign wrap       = dwell_end && (idx == LAST_IDX);
  assign frame_tick = wrap;

  // Prescaler and digit index counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (dwell_end) begin
      prescaler <= '0;
      idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Staging of new BCD words; commit only at the frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (load && wrap) begin
      display       <= bcd_in;
      pending_valid <= 1'b0;
    end else if (load) begin
      pending       <= bcd_in;
      pending_valid <= 1'b1;
    end else if (wrap && pending_valid) begin
      display       <= pending;
      pending_valid <= 1'b0;
    end
  end

  // Select the BCD nibble of the active digit.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_digit = display[4*i +: 4];
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank the active digit when it and all more-significant digits are zero;
  // digit 0 is never blanked so a zero value still shows one "0".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lead_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (display[4*i +: 4] == 4'd0);
      if ((idx == IDX_W'(i)) && upper_zero) lead_blank = 1'b1;
    end
  end
`else
  assign lead_blank = 1'b0;
`endif

  bcd_to_seg7_dec u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Next segment/strobe values: swap blanking, then display polarity.
  always_comb begin
    pattern  = (lead_blank || dwell_end) ? SEG_BLANK : dec_seg;
    led_next = LED_type_ctl ? ~pattern : pattern;
    onehot   = NUM_DIGITS'(1) << idx;
    en_next  = LED_type_ctl ? onehot : ~onehot;
  end

  // Registered display pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LED      <= '0;
      digit_en <= '0;
    end else begin
      LED      <= led_next;
      digit_en <= en_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=4).
// Stimulus pushes hand-computed {frame_tick, digit_en, LED} samples at a
// posedge; the monitor pops and compares one entry per falling edge.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  // Hand-written cathode patterns {a..g}.
  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PB = 7'b0000000;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   bcd_in;
  logic          load;
  logic          LED_type_ctl;
  logic [6:0]    LED;
  logic [ND-1:0] digit_en;
  logic          frame_tick;

  logic [11:0]   exp_q[$];
  logic [11:0]   mon_exp;
  int            errors = 0;
  int            checks = 0;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk          (clk),
    .rst          (rst),
    .bcd_in       (bcd_in),
    .load         (load),
    .LED_type_ctl (LED_type_ctl),
    .LED          (LED),
    .digit_en     (digit_en),
    .frame_tick   (frame_tick)
  );

  // Clock
  always #5 clk = ~clk;

  // Monitor: one comparison per falling edge while expectations are queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if ({frame_tick, digit_en, LED} !== mon_exp) begin
        errors++;
        $display("FAIL sample@%0t: got ft=%b en=%b led=%b, required ft=%b en=%b led=%b",
                 $time, frame_tick, digit_en, LED, mon_exp[11], mon_exp[10:7], mon_exp[6:0]);
      end
    end
  end

  // Expected samples for one frame starting the cycle after frame_tick:
  // sample 0 is digit 3's blanked last cycle, then each digit shows its
  // pattern for 3 cycles and blank for 1; frame_tick on the final sample.
  task automatic push_frame(input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3,
                            input logic anode);
    logic [6:0] pats [4];
    logic [6:0] led;
    logic [3:0] en;
    int d;
    int w;
    pats[0] = d0; pats[1] = d1; pats[2] = d2; pats[3] = d3;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) begin
        d = 3; w = 3;
      end else begin
        d = (k - 1) / 4; w = (k - 1) % 4;
      end
      led = (w == 3) ? PB : pats[d];
      if (anode) led = ~led;
      en = 4'b0001 << d;
      if (!anode) en = ~en;
      exp_q.push_back({(k == 15), en, led});
    end
  endtask

  // Bounded wait for frame_tick, sampled on the falling edge.
  task automatic wait_ft();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: got no pulse in 40 cycles, required one every 16");
    end
  endtask

  // Load a word so that it coincides with the frame_tick cycle.
  task automatic load_at_frame(input logic [15:0] value);
    wait_ft();
    load   = 1'b1;
    bcd_in = value;
  endtask

  initial begin
    rst          = 1'b1;
    load         = 1'b0;
    bcd_in       = '0;
    LED_type_ctl = 1'b0;

    // Reset: outputs held at zero.
    repeat (3) begin
      @(posedge clk);
      exp_q.push_back(12'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    exp_q.push_back({1'b0, 4'b1110, P0});

    // Basic scan, cathode: 1234 staged mid-frame, shown from the first wrap.
    @(negedge clk);
    load = 1'b1; bcd_in = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    wait_ft();
    @(posedge clk);
    push_frame(P4, P3, P2, P1, 1'b0);

    // Anode mode from the next frame.
    wait_ft();
    LED_type_ctl = 1'b1;
    @(posedge clk);
    push_frame(P4, P3, P2, P1, 1'b1);

    // Back to cathode; mid-frame back-to-back loads must not tear this frame.
    wait_ft();
    LED_type_ctl = 1'b0;
    @(posedge clk);
    push_frame(P4, P3, P2, P1, 1'b0);
    repeat (6) @(negedge clk);
    load = 1'b1; bcd_in = 16'h1111;
    @(negedge clk);
    bcd_in = 16'h5678;
    @(negedge clk);
    load = 1'b0;
    wait_ft();
    @(posedge clk);
    push_frame(P8, P7, P6, P5, 1'b0);

    // Load coinciding with frame_tick: invalid codes blank.
    load_at_frame(16'hFA09);
    @(posedge clk);
    push_frame(P9, P0, PB, PB, 1'b0);
    @(negedge clk);
    load = 1'b0;

    // Leading-zero cases.
    load_at_frame(16'h0050);
    @(posedge clk);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    push_frame(P0, P5, PB, PB, 1'b0);
`else
    push_frame(P0, P5, P0, P0, 1'b0);
`endif
    @(negedge clk);
    load = 1'b0;

    load_at_frame(16'h0000);
    @(posedge clk);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    push_frame(P0, PB, PB, PB, 1'b0);
`else
    push_frame(P0, P0, P0, P0, 1'b0);
`endif
    @(negedge clk);
    load = 1'b0;

    // Drain and report.
    repeat (18) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
